// File: rtl/game_pkg.sv
// Shared constants for the gaming-logic and graphic stages: state encoding,
// fixed-point format and screen geometry.
package game_pkg;

    localparam int FRAC_BITS = 4;
    localparam int SCREEN_H  = 480;
    localparam int BIRD_H    = 24;

    // Lowest legal bird position (top edge) in Q12.4; reaching it ends the game.
    localparam int FLOOR_Q   = (SCREEN_H - BIRD_H) << FRAC_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } game_state_t;

    function automatic logic [15:0] to_pixel(input logic [15:0] pos);
        return pos >> FRAC_BITS;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Signals between the game controller and its neighbours (scan counters in,
// bird position/state and frame events out).
interface game_ctrl_if;

    logic [15:0] sx;
    logic [15:0] sy;
    logic        collide;
    logic [15:0] bird_y;
    logic [1:0]  game_state;
    logic        frame_tick;
    logic        flap;

    modport master (
        input  sx, sy, collide,
        output bird_y, game_state, frame_tick, flap
    );

    modport slave (
        output sx, sy, collide,
        input  bird_y, game_state, frame_tick, flap
    );

endinterface

// File: rtl/btn_cond.sv
// Raw button conditioning: two-flop synchroniser, debounce counter and a
// single-cycle pulse on each accepted rising level.
module btn_cond #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic pix_clk,
    input  logic pix_rstn,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= button;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;

            // Any return to the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game state machine with Q12.4 bird physics, stepped once per frame from a
// tick derived from the scan counters.
module game_ctrl
    import game_pkg::*;
#(
    parameter int Y_START      = 228,
    parameter int GRAVITY      = 4,
    parameter int FLAP_VEL     = 64,
    parameter int MAX_FALL     = 128,
    parameter int TICK_LINE    = 480,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int DEAD_HOLD    = 60
) (
    input  logic        pix_clk,
    input  logic        pix_rstn,
    input  logic        button,
    game_ctrl_if.master bus
);

    localparam int DW = $clog2(DEAD_HOLD + 1);

    localparam logic [15:0]        POS_RST   = 16'(Y_START << FRAC_BITS);
    localparam logic [15:0]        FLOOR_POS = 16'(FLOOR_Q);
    localparam logic signed [11:0] FLAP_V    = 12'(-FLAP_VEL);
    localparam logic signed [12:0] MAX_V     = 13'(MAX_FALL);
    localparam logic [12:0]        GRAV_V    = 13'(GRAVITY);
    localparam logic [DW-1:0]      HOLD_CNT  = DW'(DEAD_HOLD);

    game_state_t        state;
    logic [15:0]        pos;
    logic signed [11:0] vel;
    logic               flap_pending;
    logic [DW-1:0]      dead_cnt;
    logic               frame_tick;
    logic               flap;

    logic               flap_now;
    logic signed [12:0] vel_wide;
    logic signed [11:0] vel_n;
    logic [16:0]        pos_wide;
    logic               ceil_hit;
    logic               floor_hit;

    btn_cond #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_cond (
        .pix_clk (pix_clk),
        .pix_rstn(pix_rstn),
        .button  (button),
        .press   (flap)
    );

    always_comb begin
        flap_now = flap_pending | flap;
        vel_wide = {vel[11], vel} + GRAV_V;
        vel_n    = vel_wide[11:0];
        if (flap_now) begin
            vel_n = FLAP_V;
        end else if (vel_wide > MAX_V) begin
            vel_n = MAX_V[11:0];
        end
        // Bit 16 is the sign of the candidate position; magnitudes are far
        // from the 16-bit limit so it cannot alias with a real overflow.
        pos_wide  = {1'b0, pos} + {{5{vel_n[11]}}, vel_n};
        ceil_hit  = pos_wide[16];
        floor_hit = !pos_wide[16] && (pos_wide[15:0] >= FLOOR_POS);
    end

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            state        <= ST_IDLE;
            pos          <= POS_RST;
            vel          <= '0;
            flap_pending <= 1'b0;
            dead_cnt     <= '0;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= (bus.sx == 16'd0) && (bus.sy == 16'(TICK_LINE));

            case (state)
                ST_IDLE: begin
                    if (flap) begin
                        state        <= ST_PLAY;
                        flap_pending <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (frame_tick) begin
                        flap_pending <= 1'b0;
                        if (ceil_hit) begin
                            pos <= '0;
                            vel <= '0;
                        end else if (floor_hit) begin
                            pos <= FLOOR_POS;
                            vel <= '0;
                        end else begin
                            pos <= pos_wide[15:0];
                            vel <= vel_n;
                        end
                    end else if (flap) begin
                        flap_pending <= 1'b1;
                    end

                    if (bus.collide || (frame_tick && floor_hit)) begin
                        state <= ST_DEAD;
                    end
                end

                ST_DEAD: begin
                    if (flap && (dead_cnt == HOLD_CNT)) begin
                        state        <= ST_IDLE;
                        pos          <= POS_RST;
                        vel          <= '0;
                        flap_pending <= 1'b0;
                        dead_cnt     <= '0;
                    end else if (frame_tick && (dead_cnt != HOLD_CNT)) begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bird_y     = to_pixel(pos);
    assign bus.game_state = state;
    assign bus.frame_tick = frame_tick;
    assign bus.flap       = flap;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed plus randomised bench for game_ctrl, checked against an
// event-level model of the game rules.
module tb_game_ctrl;

    localparam int DEB  = 8;
    localparam int DH   = 3;
    localparam int TICK = 480;
    localparam int YS   = 228;
    localparam int FLOOR_PIX = 480 - 24;

    logic pix_clk  = 1'b0;
    logic pix_rstn = 1'b0;
    logic button   = 1'b0;

    game_ctrl_if gif();

    game_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .DEAD_HOLD   (DH)
    ) dut (
        .pix_clk (pix_clk),
        .pix_rstn(pix_rstn),
        .button  (button),
        .bus     (gif.master)
    );

    always #5 pix_clk = ~pix_clk;

    int checks = 0;
    int errors = 0;

    // Model of the game: position in 1/16 px, velocity in 1/16 px/frame.
    int m_pos, m_vel, m_state, m_pend, m_dead;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " state"}, 32'(gif.game_state), 32'(m_state));
        chk({tag, " bird_y"}, 32'(gif.bird_y), 32'(m_pos / 16));
    endtask

    function automatic void m_reset();
        m_pos   = YS * 16;
        m_vel   = 0;
        m_state = 0;
        m_pend  = 0;
        m_dead  = 0;
    endfunction

    // One game event: a frame tick, an accepted press and/or a collide level.
    function automatic void m_event(input bit tick, input bit flp, input bit col);
        int vn, pn;
        if (m_state == 0) begin
            if (flp) begin
                m_state = 1;
                m_pend  = 1;
            end
        end else if (m_state == 1) begin
            if (tick) begin
                if (m_pend != 0 || flp) vn = -64;
                else vn = (m_vel + 4 > 128) ? 128 : m_vel + 4;
                pn = m_pos + vn;
                m_pend = 0;
                if (pn < 0) begin
                    m_pos = 0;
                    m_vel = 0;
                end else if (pn >= FLOOR_PIX * 16) begin
                    m_pos   = FLOOR_PIX * 16;
                    m_vel   = 0;
                    m_state = 2;
                end else begin
                    m_pos = pn;
                    m_vel = vn;
                end
            end else if (flp) begin
                m_pend = 1;
            end
            if (col) m_state = 2;
        end else begin
            if (flp && m_dead == DH) m_reset();
            else if (tick && m_dead < DH) m_dead++;
        end
    endfunction

    task automatic do_tick(input bit col);
        gif.sx = 16'd0;
        gif.sy = 16'(TICK);
        @(negedge pix_clk);
        chk("frame_tick pulse", 32'(gif.frame_tick), 32'd1);
        gif.sx      = 16'd5;
        gif.sy      = 16'd0;
        gif.collide = col;
        @(negedge pix_clk);
        gif.collide = 1'b0;
        m_event(1'b1, 1'b0, col);
        chk_all("tick");
        chk("frame_tick width", 32'(gif.frame_tick), 32'd0);
    endtask

    task automatic do_press(input bit with_tick);
        bit early = 0;
        bit extra = 0;
        button = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            if (with_tick && i == 11) begin
                gif.sx = 16'd0;
                gif.sy = 16'(TICK);
            end
            @(negedge pix_clk);
            if (i < 11 && gif.flap) early = 1;
        end
        chk("flap early", 32'(early), 32'd0);
        chk("flap latency", 32'(gif.flap), 32'd1);
        if (with_tick) chk("tick with flap", 32'(gif.frame_tick), 32'd1);
        gif.sx = 16'd5;
        gif.sy = 16'd0;
        @(negedge pix_clk);
        m_event(with_tick, 1'b1, 1'b0);
        chk_all("press");
        chk("flap single", 32'(gif.flap), 32'd0);
        button = 1'b0;
        repeat (12) begin
            @(negedge pix_clk);
            if (gif.flap) extra = 1;
        end
        chk("flap on release", 32'(extra), 32'd0);
    endtask

    task automatic do_collide();
        gif.collide = 1'b1;
        @(negedge pix_clk);
        gif.collide = 1'b0;
        m_event(1'b0, 1'b0, 1'b1);
        chk_all("collide");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        gif.sx      = 16'd5;
        gif.sy      = 16'd0;
        gif.collide = 1'b0;
        m_reset();
        repeat (3) @(negedge pix_clk);
        chk("reset bird_y", 32'(gif.bird_y), 32'(YS));
        chk("reset state", 32'(gif.game_state), 32'd0);
        chk("reset frame_tick", 32'(gif.frame_tick), 32'd0);
        chk("reset flap", 32'(gif.flap), 32'd0);
        pix_rstn = 1'b1;
        @(negedge pix_clk);
        chk_all("after reset");

        // Short glitch must not be accepted.
        seen = 0;
        button = 1'b1;
        repeat (5) @(negedge pix_clk);
        button = 1'b0;
        repeat (15) begin
            @(negedge pix_clk);
            if (gif.flap) seen = 1;
        end
        chk("glitch no flap", 32'(seen), 32'd0);

        do_collide();
        do_tick(1'b0);
        gif.sx = 16'd1;
        gif.sy = 16'(TICK);
        @(negedge pix_clk);
        @(negedge pix_clk);
        chk("no tick sx=1", 32'(gif.frame_tick), 32'd0);
        gif.sx = 16'd0;
        gif.sy = 16'(TICK - 1);
        @(negedge pix_clk);
        @(negedge pix_clk);
        chk("no tick sy=479", 32'(gif.frame_tick), 32'd0);
        gif.sx = 16'd5;
        gif.sy = 16'd0;

        // Start and first flap.
        do_press(1'b0);
        chk("start state", 32'(gif.game_state), 32'd1);
        do_tick(1'b0);
        chk("first tick bird_y", 32'(gif.bird_y), 32'd224);
        do_tick(1'b0);
        chk("second tick bird_y", 32'(gif.bird_y), 32'd220);

        // Free fall to the floor.
        for (int i = 0; i < 200 && m_state == 1; i++) do_tick(1'b0);
        chk("floor bird_y", 32'(gif.bird_y), 32'(FLOOR_PIX));
        chk("floor state", 32'(gif.game_state), 32'd2);

        // Restart hold.
        do_tick(1'b0);
        do_tick(1'b0);
        do_press(1'b0);
        chk("early restart ignored", 32'(gif.game_state), 32'd2);
        do_tick(1'b0);
        do_press(1'b0);
        chk("restart state", 32'(gif.game_state), 32'd0);
        chk("restart bird_y", 32'(gif.bird_y), 32'(YS));

        // Ceiling: a flap on every tick.
        do_press(1'b0);
        n = 0;
        while (n < 70 && !(m_pos == 0 && m_vel == 0)) begin
            do_press(1'b1);
            n++;
        end
        chk("ceiling reached", 32'(m_pos == 0 && m_vel == 0), 32'd1);
        chk("ceiling bird_y", 32'(gif.bird_y), 32'd0);
        chk("ceiling state", 32'(gif.game_state), 32'd1);

        do_collide();
        chk("collide in play", 32'(gif.game_state), 32'd2);

        // Randomised mix of events.
        for (int i = 0; i < 120; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 4)      do_tick(1'b0);
            else if (r == 5) do_tick(1'b1);
            else if (r <= 7) do_press(1'b0);
            else if (r == 8) do_press(1'b1);
            else             do_collide();
            repeat ($urandom_range(0, 3)) begin
                gif.sx = 16'($urandom_range(1, 799));
                gif.sy = 16'($urandom_range(0, 524));
                @(negedge pix_clk);
                chk_all("idle gap");
            end
            gif.sx = 16'd5;
            gif.sy = 16'd0;
        end

        // Get into PLAY and reset asynchronously.
        for (int i = 0; i < 10 && m_state != 1; i++) begin
            if (m_state == 2 && m_dead < DH) do_tick(1'b0);
            else do_press(1'b0);
        end
        do_press(1'b1);
        chk("pre-reset state", 32'(gif.game_state), 32'd1);
        gif.sx = 16'd0;
        gif.sy = 16'(TICK);
        @(posedge pix_clk);
        #2;
        chk("pre-reset frame_tick", 32'(gif.frame_tick), 32'd1);
        pix_rstn = 1'b0;
        #1;
        m_reset();
        chk("async reset bird_y", 32'(gif.bird_y), 32'(YS));
        chk("async reset state", 32'(gif.game_state), 32'd0);
        chk("async reset frame_tick", 32'(gif.frame_tick), 32'd0);
        chk("async reset flap", 32'(gif.flap), 32'd0);
        gif.sx = 16'd5;
        gif.sy = 16'd0;
        @(negedge pix_clk);
        pix_rstn = 1'b1;
        @(negedge pix_clk);
        chk_all("after release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Gaming-logic stage between the button pin and the graphic stage.
- Conditions the raw button: synchronise, debounce, rising-edge detect.
- Derives a once-per-frame tick from the scan counters and runs the game state machine with fixed-point bird physics.
- Outputs bird vertical position and game state; the graphic stage consumes both.

Parameters:
- SCREEN_H, 480, active lines.
- BIRD_H, 24, bird sprite height in pixels.
- Y_START, 228, bird top-edge pixel row in IDLE.
- FRAC_BITS, 4, fractional bits of position and velocity.
- GRAVITY, 4, velocity increment per frame (Q.4 units, i.e. 0.25 px/frame²).
- FLAP_VEL, 64, upward speed set by a flap (Q.4, 4 px/frame).
- MAX_FALL, 128, downward velocity cap (Q.4, 8 px/frame).
- TICK_LINE, 480, sy value at which the frame tick fires (first blanking line).
- DEBOUNCE_CYC, 250000, stable cycles required to accept a button level change.
- DEAD_HOLD, 60, frames in DEAD before a press is accepted.

Ports:
- pix_clk  in  1  pixel clock
- pix_rstn  in  1  asynchronous active-low reset
- button  in  1  raw button, active-high, asynchronous
- sx  in  16  scan x from vga_scan
- sy  in  16  scan y from vga_scan
- collide  in  1  level from graphic stage: bird overlaps a pipe
- bird_y  out  16  bird top-edge pixel row (integer part of position)
- game_state  out  2  0=IDLE, 1=PLAY, 2=DEAD
- frame_tick  out  1  one-cycle pulse per frame
- flap  out  1  one-cycle debounced press pulse

Behaviour:
- Reset: pix_clk only; pix_rstn clears all flops asynchronously, release is synchronous externally.
- Reset values: state IDLE; pos = Y_START<<FRAC_BITS; vel = 0; flap_pending = 0; dead_cnt = 0; sync/debounce flops 0; counter 0.
- Reset-derived outputs: bird_y = Y_START, game_state = 0, frame_tick = 0, flap = 0.
- Button path: 2-FF synchroniser; debounce counter counts while synced level differs from accepted level and clears when they match.
- Debounce acceptance: at DEBOUNCE_CYC the counter toggles the accepted level.
- flap: registered pulse on accepted 0->1. Latency is 2 + DEBOUNCE_CYC + 1 cycles after a clean edge. A held button gives one pulse.
- frame_tick: registered, high for the one cycle after sx==0 && sy==TICK_LINE is seen.
- Position and velocity: pos is unsigned 16-bit Q12.4; vel is signed 12-bit Q.4, positive = down; bird_y = pos >> FRAC_BITS.
- flap_now = flap_pending | flap. Sets flap_pending, consumed (cleared) by the next frame_tick in PLAY. A press coincident with a tick is consumed by that tick.
- IDLE: pos and vel held at reset values. flap -> PLAY with flap_pending set; the transition happens on the flap cycle.
- PLAY, on frame_tick:
  - vel_n = flap_now ? -FLAP_VEL : min(vel+GRAVITY, MAX_FALL).
  - pos_n = pos + vel_n, computed signed 17-bit.
  - Ceiling: pos_n < 0 gives pos = 0, vel = 0.
  - Floor: pos_n >= (SCREEN_H-BIRD_H)<<FRAC_BITS gives pos clamped to that value, vel = 0, state DEAD.
  - Otherwise pos = pos_n, vel = vel_n.
- PLAY, collide: collide high on any cycle goes to DEAD next cycle with pos/vel frozen. Collide and floor on the same tick both give DEAD, with floor clamp applied.
- DEAD:
  - dead_cnt increments per frame_tick, saturating at DEAD_HOLD.
  - A flap while dead_cnt == DEAD_HOLD goes to IDLE and restores reset values for pos, vel, flap_pending, dead_cnt.
  - Earlier flaps are ignored and do not set flap_pending.
- collide is ignored in IDLE and DEAD.
- Flops not listed as changing in a state hold their value.
- game_state and bird_y are registered directly from state/pos; no extra output latency.

Decomposition:
- Shared package game_pkg:
  - state encoding constants ST_IDLE/ST_PLAY/ST_DEAD;
  - FRAC_BITS and screen-geometry constants SCREEN_H, BIRD_H, also used by graphic.
- One sub-module, btn_cond: synchroniser, debounce counter and rising-edge pulse, parameter DEBOUNCE_CYC.
- FSM and physics stay in game_ctrl.

Test Plan:
- Debounce (DEBOUNCE_CYC=8): glitch button 0->1 for 5 cycles then 0 -> no flap. Hold high 20 cycles -> exactly one flap pulse, 11 cycles after the edge.
- Start and first flap: from reset, bird_y=228, state 0. Press -> state 1. Next tick -> vel=-64, bird_y=224. Following tick -> vel=-60, pos=3524, bird_y=220.
- Free fall and cap: no presses after start. vel climbs by 4 per tick and saturates at 128, never exceeding it. bird_y reaches 456, then state=2, vel=0, bird_y stays 456.
- Ceiling: flap on every tick from bird_y=4 -> bird_y=0, vel=0, state remains 1.
- Collide and same-cycle tick: press on the tick cycle is applied by that tick (vel=-64). collide pulse in PLAY -> state 2 next cycle, bird_y frozen. collide in IDLE -> no change.
- Restart hold and reset (DEAD_HOLD=3): press after 2 DEAD ticks -> stays DEAD. Press after 3 -> IDLE, bird_y=228. pix_rstn low mid-PLAY -> all outputs at reset values immediately, without waiting for a clock.
